// File: rtl/bus_pkg.sv
// Shared types and constants for the bus interconnect: FSM state encoding,
// slave-index width helper, default address map and the error read value.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Upper limits the default-map builder is sized for.
    localparam int MAX_SLAVES   = 16;
    localparam int MAX_ADDR_W   = 64;
    localparam int MAP_W        = MAX_SLAVES * MAX_ADDR_W;

    // Default map: slave k lives at k * 4 KiB with a 4 KiB window.
    localparam int                    SLAVE_STRIDE_LOG2 = 12;
    localparam logic [MAX_ADDR_W-1:0] DEFAULT_MASK      = ~64'h0000_0000_0000_0FFF;

    // Read data returned with an error response.
    localparam logic [MAX_ADDR_W-1:0] ERR_RDATA = '0;

    // Width of a slave index; a single slave still gets one bit.
    function automatic int SLV_IDX_W(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

    // Builds a packed per-slave map (slot k at bits [k*addr_w +: addr_w]).
    // is_mask selects the default mask table instead of the base table.
    function automatic logic [MAP_W-1:0] default_map(input int addr_w, input logic is_mask);
        logic [MAP_W-1:0]      map;
        logic [MAX_ADDR_W-1:0] keep;
        logic [MAX_ADDR_W-1:0] slot;
        map  = '0;
        keep = {MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - addr_w);
        for (int k = 0; k < MAX_SLAVES; k++) begin
            slot = is_mask ? DEFAULT_MASK : (MAX_ADDR_W'(k) << SLAVE_STRIDE_LOG2);
            slot = slot & keep;
            map  = map | (MAP_W'(slot) << (k * addr_w));
        end
        return map;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: compares the address against every slave's
// base/mask pair and priority-encodes the matches, lowest index winning.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                         N_SLAVES   = 8,
    parameter int                         ADDR_W     = 32,
    parameter int                         IDX_W      = SLV_IDX_W(N_SLAVES),
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the highest slot down so the lowest matching slot is left last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// CPU-to-peripheral bus interconnect. Decodes each request against a
// per-slave base/mask map, runs a request/ready transaction with wait states
// and returns an error response for unmapped addresses. With the macro
// BUS_INTERCONNECT_TIMEOUT_EN defined, a slave that does not answer within
// TIMEOUT access cycles is aborted with an error; without it the bus waits
// for ready_i indefinitely. All outputs come straight from registers.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int                         N_SLAVES   = 8,
    parameter int                         ADDR_W     = 32,
    parameter int                         DATA_W     = 32,
    parameter int                         TIMEOUT    = 15,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = (N_SLAVES*ADDR_W)'(default_map(ADDR_W, 1'b0)),
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = (N_SLAVES*ADDR_W)'(default_map(ADDR_W, 1'b1))
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         ready_o,
    output logic                         err_o,
    output logic [ADDR_W-1:0]            err_addr_o,
    output logic [N_SLAVES-1:0]          sel_o,
    output logic [N_SLAVES-1:0]          we_o,
    output logic [ADDR_W-1:0]            addr_o,
    output logic [DATA_W-1:0]            wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0]   rdata_i,
    input  logic [N_SLAVES-1:0]          ready_i
);

    localparam int IDX_W = SLV_IDX_W(N_SLAVES);

    // Reject unsupported configurations at elaboration.
    if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES) begin : g_bad_n_slaves
        $error("bus_interconnect: N_SLAVES must be 1..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_interconnect: TIMEOUT must be 1..255");
    end

    state_t              state_q,    state_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic                we_q,       we_d;
    logic [N_SLAVES-1:0] sel_q,      sel_d;
    logic [N_SLAVES-1:0] wen_q,      wen_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic                ready_q,    ready_d;
    logic                err_q,      err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

`ifdef BUS_INTERCONNECT_TIMEOUT_EN
    // Last access cycle before the slave is given up on.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]          cnt_q,      cnt_d;
`endif

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                slave_ready;
    logic [DATA_W-1:0]   slave_rdata;

    bus_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr (addr_i),
        .hit  (hit),
        .idx  (hit_idx)
    );

    // Only the latched slave's ready and read data are ever looked at.
    assign slave_ready = ready_i[idx_q];
    assign slave_rdata = rdata_i[int'(idx_q)*DATA_W +: DATA_W];

    // Next-state and next-output logic for the IDLE/ACCESS/RESP transaction FSM.
    always_comb begin
        // NOTE: every *_d gets a default before the case so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        we_d       = we_q;
        sel_d      = '0;
        wen_d      = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
`ifdef BUS_INTERCONNECT_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (hit) begin
                        state_d = ACCESS;
                        idx_d   = hit_idx;
                        we_d    = we_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        for (int k = 0; k < N_SLAVES; k++) begin
                            sel_d[k] = (hit_idx == IDX_W'(k));
                        end
                        wen_d   = we_i ? sel_d : '0;
`ifdef BUS_INTERCONNECT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Unmapped: answer with an error on the very next cycle.
                        state_d    = RESP;
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        rdata_d    = DATA_W'(ERR_RDATA);
                        err_addr_d = addr_i;
                    end
                end
            end

            ACCESS: begin
                if (slave_ready) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : slave_rdata;
                end
`ifdef BUS_INTERCONNECT_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = RESP;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = DATA_W'(ERR_RDATA);
                    err_addr_d = addr_q;
                end
`endif
                else begin
                    sel_d = sel_q;
                    wen_d = wen_q;
`ifdef BUS_INTERCONNECT_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end

            RESP: begin
                // Completion strobe is up this cycle; new requests wait for IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register every FSM and output value; async reset clears the lot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: all of these are control/datapath registers (no storage array), so each one is reset.
        if (!rst_n_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wen_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifdef BUS_INTERCONNECT_TIMEOUT_EN
    // Access-cycle counter used to abort unresponsive slaves.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign rdata_o    = rdata_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign sel_o      = sel_q;
    assign we_o       = wen_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard testbench for bus_interconnect. The stimulus process pushes the
// expected response of each transaction into a queue; a monitor process pops
// and compares whenever ready_o is seen. Slaves are modelled with a
// per-slave programmable wait count. Slot 4 of the map overlaps slot 3.
module tb_bus_interconnect;

    localparam int N   = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 15;

    localparam logic [N*AW-1:0] BASE_MAP = {32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_3000,
                                            32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [N*AW-1:0] MASK_MAP = {N{32'hFFFF_F000}};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] err_addr;
        logic [7:0]  sel;
        int          sel_cycles;
        int          we_cycles;
        int          latency;
        logic [31:0] addr_o;
        logic [31:0] wdata_o;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata_o;
    logic              ready_o;
    logic              err_o;
    logic [AW-1:0]     err_addr_o;
    logic [N-1:0]      sel_o;
    logic [N-1:0]      we_o;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     wdata_o;
    logic [N*DW-1:0]   rdata_i;
    logic [N-1:0]      ready_i;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                delay_cfg[N];
    logic [N-1:0]      spurious;

    // Reference model of the sticky outputs.
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_err_addr;

    bus_interconnect #(
        .N_SLAVES   (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TMO),
        .SLAVE_BASE (BASE_MAP),
        .SLAVE_MASK (MASK_MAP)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .err_addr_o (err_addr_o),
        .sel_o      (sel_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .rdata_i    (rdata_i),
        .ready_i    (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: slave k raises ready after delay_cfg[k] selected cycles.
    initial begin
        int         left [N];
        logic [2:0] ki;
        ready_i = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                ki = 3'(k);
                if (sel_o[ki]) begin
                    if (left[k] == 0) begin
                        ready_i[ki] = 1'b1;
                    end else begin
                        left[k]--;
                        ready_i[ki] = spurious[ki];
                    end
                end else begin
                    left[k]     = delay_cfg[k];
                    ready_i[ki] = spurious[ki];
                end
            end
        end
    end

    // Monitor: accumulates select/latency info and checks each response.
    initial begin
        logic [7:0] acc;
        int         selc;
        int         wec;
        int         lat;
        exp_t       e;
        acc = '0; selc = 0; wec = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc = '0; selc = 0; wec = 0; lat = 0;
            end else begin
                if (req) lat++;
                if (sel_o != '0) begin
                    acc = acc | sel_o;
                    selc++;
                end
                if (we_o != '0) begin
                    wec++;
                    check("we_inside_sel", 64'(we_o & ~sel_o), 64'(0));
                end
                if (ready_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_ready: ready_o=1 with no outstanding request");
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata",      64'(rdata_o),    64'(e.rdata));
                        check("err",        64'(err_o),      64'(e.err));
                        check("err_addr",   64'(err_addr_o), 64'(e.err_addr));
                        check("sel_onehot", 64'(acc),        64'(e.sel));
                        check("sel_cycles", 64'(selc),       64'(e.sel_cycles));
                        check("we_cycles",  64'(wec),        64'(e.we_cycles));
                        check("latency",    64'(lat),        64'(e.latency));
                        check("addr_o",     64'(addr_o),     64'(e.addr_o));
                        check("wdata_o",    64'(wdata_o),    64'(e.wdata_o));
                    end
                    acc = '0; selc = 0; wec = 0; lat = 0;
                end
            end
        end
    end

    // Issue one transaction; wait_cyc is the number of cycles the slave holds ready low.
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [31:0] e_rdata, input logic e_err, input logic [7:0] e_sel,
                           input int wait_cyc);
        exp_t e;
        bit   done;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.sel   = e_sel;
        if (e_sel != '0) begin
            e.sel_cycles = wait_cyc + 1;
            e.latency    = wait_cyc + 2;
            m_addr       = t_addr;
            m_wdata      = t_wdata;
        end else begin
            e.sel_cycles = 0;
            e.latency    = 1;
        end
        e.we_cycles = t_we ? e.sel_cycles : 0;
        if (e_err) m_err_addr = t_addr;
        e.err_addr = m_err_addr;
        e.addr_o   = m_addr;
        e.wdata_o  = m_wdata;
        exp_q.push_back(e);

        @(negedge clk);
        #1;
        req   = 1'b1;
        we    = t_we;
        addr  = t_addr;
        wdata = t_wdata;
        done  = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (ready_o) done = 1'b1;
        end
        #1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait: no ready_o within 200 cycles for addr 0x%08h", t_addr);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},      64'(sel_o),      64'(0));
        check({tag, "_we"},       64'(we_o),       64'(0));
        check({tag, "_ready"},    64'(ready_o),    64'(0));
        check({tag, "_err"},      64'(err_o),      64'(0));
        check({tag, "_rdata"},    64'(rdata_o),    64'(0));
        check({tag, "_err_addr"}, 64'(err_addr_o), 64'(0));
        check({tag, "_addr_o"},   64'(addr_o),     64'(0));
        check({tag, "_wdata_o"},  64'(wdata_o),    64'(0));
    endtask

    // Main directed stimulus.
    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        spurious = '0;
        m_addr = '0; m_wdata = '0; m_err_addr = '0;
        for (int k = 0; k < N; k++) begin
            delay_cfg[k] = 0;
            rdata_i[k*DW +: DW] = 32'(32'h1111_1111 * k);
        end
        rdata_i[2*DW +: DW] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        // Zero-wait read of slave 2.
        delay_cfg[2] = 0;
        run_txn(1'b0, 32'h0000_2004, 32'h0000_0000, 32'h1234_5678, 1'b0, 8'h04, 0);

        // Write to slave 0 with three wait cycles.
        delay_cfg[0] = 3;
        run_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 8'h01, 3);

        // Unmapped read; addr_o/wdata_o must keep the previous access.
        run_txn(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 8'h00, 0);

`ifdef BUS_INTERCONNECT_TIMEOUT_EN
        // Slave 5 never answers: aborted after TIMEOUT selected cycles.
        delay_cfg[5] = 1000;
        run_txn(1'b0, 32'h0000_5008, 32'h0000_5A5A, 32'h0000_0000, 1'b1, 8'h20, TMO - 1);
`else
        // Slave 5 answers late; with no timeout the bus simply waits.
        delay_cfg[5] = 20;
        run_txn(1'b0, 32'h0000_5008, 32'h0000_5A5A, 32'h5555_5555, 1'b0, 8'h20, 20);
`endif

        // Overlapping slots 3 and 4: slot 3 wins; stray ready on 4 and 7 is ignored.
        delay_cfg[3] = 2;
        spurious     = 8'h90;
        run_txn(1'b0, 32'h0000_3010, 32'h0000_0000, 32'h3333_3333, 1'b0, 8'h08, 2);
        spurious     = '0;

        // Reset during the second ACCESS cycle of a write to slave 6.
        delay_cfg[6] = 100;
        @(negedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 32'h0000_6ABC; wdata = 32'h6666_0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_sel", 64'(sel_o), 64'(8'h40));
        check("pre_reset_we",  64'(we_o),  64'(8'h40));
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        m_addr = '0; m_wdata = '0; m_err_addr = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Normal read of slave 1 after reset, one wait cycle.
        delay_cfg[1] = 1;
        run_txn(1'b0, 32'h0000_1FFC, 32'h0BAD_0BAD, 32'h1111_1111, 1'b0, 8'h02, 1);

        // Zero-wait write to the top slave.
        delay_cfg[7] = 0;
        run_txn(1'b1, 32'h0000_7ABC, 32'h0123_4567, 32'h0000_0000, 1'b0, 8'h80, 0);

        // Just past the top of the map: unmapped write.
        run_txn(1'b1, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 8'h00, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
